// File: rtl/game_pkg.sv
// Shared types and default constants for the match judge.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        JUDGE  = 2'd1,
        REPORT = 2'd2,
        OVER   = 2'd3
    } judge_state_t;

    localparam int DEF_N_PLAYERS = 2;
    localparam int DEF_CODE_W    = 5;
    localparam int DEF_SCORE_W   = 4;
    localparam int DEF_WIN_SCORE = 9;

endpackage

// File: rtl/max_mask.sv
// Flags every player whose move code equals the unsigned maximum.
module max_mask #(
    parameter int N_PLAYERS = 2,
    parameter int CODE_W    = 5
) (
    input  logic [N_PLAYERS*CODE_W-1:0] codes,
    output logic [N_PLAYERS-1:0]        mask
);

    logic [CODE_W-1:0] max_c;

    always_comb begin
        max_c = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (codes[i*CODE_W +: CODE_W] > max_c) begin
                max_c = codes[i*CODE_W +: CODE_W];
            end
        end
        mask = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            mask[i] = (codes[i*CODE_W +: CODE_W] == max_c);
        end
    end

endmodule

// File: rtl/match_judge.sv
// Round judge: latch codes, pick max-code winners, keep score to WIN_SCORE.
module match_judge
    import game_pkg::*;
#(
    parameter int N_PLAYERS = DEF_N_PLAYERS,
    parameter int CODE_W    = DEF_CODE_W,
    parameter int SCORE_W   = DEF_SCORE_W,
    parameter int WIN_SCORE = DEF_WIN_SCORE
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [N_PLAYERS*CODE_W-1:0]  Out_cr,
    input  logic                         round_valid,
    input  logic                         new_match,
    output logic                         ready,
    output logic [N_PLAYERS-1:0]         Out_wr,
    output logic                         result_valid,
    output logic [N_PLAYERS*SCORE_W-1:0] scores,
    output logic                         match_over,
    output logic [2:0]                   champion
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    judge_state_t                state;
    logic [N_PLAYERS*CODE_W-1:0] codes_q;
    logic [N_PLAYERS-1:0]        mask;
    logic                        sole;
    logic [SCORE_W-1:0]          score_q [N_PLAYERS];
    logic                        any_win;
    logic [2:0]                  win_idx;

    max_mask #(
        .N_PLAYERS(N_PLAYERS),
        .CODE_W   (CODE_W)
    ) u_max_mask (
        .codes(codes_q),
        .mask (mask)
    );

    assign sole  = $onehot(mask);
    assign ready = (state == IDLE);

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_pack
        assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
    end

    // Lowest-indexed player at WIN_SCORE; only one can get there per round.
    always_comb begin
        any_win = 1'b0;
        win_idx = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (score_q[i] == WIN) begin
                any_win = 1'b1;
                win_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge Clock) begin
        result_valid <= 1'b0;
        if (Reset || new_match) begin
            state      <= IDLE;
            codes_q    <= '0;
            Out_wr     <= '0;
            match_over <= 1'b0;
            champion   <= '0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                score_q[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (round_valid) begin
                        codes_q <= Out_cr;
                        state   <= JUDGE;
                    end
                end
                JUDGE: begin
                    Out_wr       <= mask;
                    result_valid <= 1'b1;
                    state        <= REPORT;
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (sole && mask[i] && score_q[i] != WIN) begin
                            score_q[i] <= score_q[i] + SCORE_W'(1);
                        end
                    end
                end
                REPORT: begin
                    if (any_win) begin
                        state      <= OVER;
                        match_over <= 1'b1;
                        champion   <= win_idx;
                    end else begin
                        state <= IDLE;
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_match_judge.sv
// Directed bench for match_judge: 2-player default and a 4-player build.
module tb_match_judge;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  cr;
    logic        rv;
    logic        nm;
    logic        rdy;
    logic [1:0]  wr;
    logic        res_v;
    logic [7:0]  sc;
    logic        over;
    logic [2:0]  champ;

    logic [11:0] cr4;
    logic        rv4;
    logic        rdy4;
    logic [3:0]  wr4;
    logic        res_v4;
    logic [15:0] sc4;
    logic        over4;
    logic [2:0]  champ4;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    match_judge dut (
        .Clock       (clk),
        .Reset       (rst),
        .Out_cr      (cr),
        .round_valid (rv),
        .new_match   (nm),
        .ready       (rdy),
        .Out_wr      (wr),
        .result_valid(res_v),
        .scores      (sc),
        .match_over  (over),
        .champion    (champ)
    );

    match_judge #(
        .N_PLAYERS(4),
        .CODE_W   (3)
    ) dut4 (
        .Clock       (clk),
        .Reset       (rst),
        .Out_cr      (cr4),
        .round_valid (rv4),
        .new_match   (1'b0),
        .ready       (rdy4),
        .Out_wr      (wr4),
        .result_valid(res_v4),
        .scores      (sc4),
        .match_over  (over4),
        .champion    (champ4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic round(input logic [9:0] c, input logic [1:0] ewr,
                         input logic [7:0] esc);
        cr = c;
        rv = 1'b1;
        tick();
        rv = 1'b0;
        chk("judge_ready", {31'd0, rdy}, 32'd0);
        chk("judge_rv", {31'd0, res_v}, 32'd0);
        tick();
        chk("report_rv", {31'd0, res_v}, 32'd1);
        chk("report_wr", {30'd0, wr}, {30'd0, ewr});
        chk("report_sc", {24'd0, sc}, {24'd0, esc});
        tick();
        chk("after_rv", {31'd0, res_v}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cr  = '0;
        rv  = 1'b0;
        nm  = 1'b0;
        cr4 = '0;
        rv4 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", {31'd0, rdy}, 32'd1);
        chk("rst_sc", {24'd0, sc}, 32'd0);
        chk("rst_wr", {30'd0, wr}, 32'd0);
        chk("rst_rv", {31'd0, res_v}, 32'd0);
        chk("rst_over", {31'd0, over}, 32'd0);
        chk("rst_champ", {29'd0, champ}, 32'd0);

        // 4-player tie between players 1 and 2
        cr4 = {3'd2, 3'd7, 3'd7, 3'd5};
        rv4 = 1'b1;
        tick();
        rv4 = 1'b0;
        tick();
        chk("p4_rv", {31'd0, res_v4}, 32'd1);
        chk("p4_wr", {28'd0, wr4}, 32'h6);
        chk("p4_sc", {16'd0, sc4}, 32'd0);
        tick();
        chk("p4_ready", {31'd0, rdy4}, 32'd1);

        round(10'b10011_00110, 2'b10, 8'h10);
        chk("idle_ready", {31'd0, rdy}, 32'd1);
        round(10'b00111_00111, 2'b11, 8'h10);

        nm = 1'b1;
        tick();
        nm = 1'b0;
        chk("nm_sc", {24'd0, sc}, 32'd0);
        chk("nm_wr", {30'd0, wr}, 32'd0);

        for (int i = 1; i <= 9; i++) begin
            round(10'b00000_00101, 2'b01, 8'(i));
        end
        chk("over_flag", {31'd0, over}, 32'd1);
        chk("over_champ", {29'd0, champ}, 32'd0);
        chk("over_sc", {24'd0, sc}, 32'h09);
        chk("over_ready", {31'd0, rdy}, 32'd0);

        cr = 10'b11111_00000;
        rv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("over_ign_rv", {31'd0, res_v}, 32'd0);
        end
        rv = 1'b0;
        chk("over_hold_sc", {24'd0, sc}, 32'h09);
        chk("over_hold_wr", {30'd0, wr}, 32'h1);
        chk("over_hold_flag", {31'd0, over}, 32'd1);

        nm = 1'b1;
        tick();
        nm = 1'b0;
        chk("nm2_sc", {24'd0, sc}, 32'd0);
        chk("nm2_over", {31'd0, over}, 32'd0);
        chk("nm2_ready", {31'd0, rdy}, 32'd1);

        // new_match beats round_valid in the same cycle
        cr = 10'b00001_00000;
        rv = 1'b1;
        nm = 1'b1;
        tick();
        rv = 1'b0;
        nm = 1'b0;
        chk("prio_ready", {31'd0, rdy}, 32'd1);
        tick();
        tick();
        chk("prio_rv", {31'd0, res_v}, 32'd0);
        chk("prio_sc", {24'd0, sc}, 32'd0);

        round(10'b00010_00001, 2'b10, 8'h10);

        cr = 10'b00000_00011;
        rv = 1'b1;
        tick();
        rv = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("jrst_rv", {31'd0, res_v}, 32'd0);
        chk("jrst_ready", {31'd0, rdy}, 32'd1);
        chk("jrst_sc", {24'd0, sc}, 32'd0);
        chk("jrst_wr", {30'd0, wr}, 32'd0);
        chk("jrst_over", {31'd0, over}, 32'd0);
        chk("jrst_champ", {29'd0, champ}, 32'd0);
        tick();
        chk("jrst_rv2", {31'd0, res_v}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
